// File: rtl/delayfixed_fall_dig.sv
// Delayed-fall level follower: rising edges of i pass with synchroniser latency only,
// falling edges are held off until i has been low for DELAY_CYCLES consecutive clocks.
// Latency: rise SYNC_STAGES+1 edges, fall SYNC_STAGES+DELAY_CYCLES edges; no backpressure.
module delayfixed_fall_dig #(
    parameter int DELAY_CYCLES = 10,
    parameter int SYNC_STAGES  = 2,
    localparam int CNT_W       = $clog2(DELAY_CYCLES)
) (
    input  logic clk,
    input  logic rst,
    input  logic CELV,
    input  logic CELG,
    input  logic CELSUB,
    input  logic i,
    output logic o,
    output logic busy,
    output logic fall_pulse
);

    // The hold-off needs at least two low samples to mean anything, and a
    // single flop is not a synchroniser; refuse to build either case.
    if (DELAY_CYCLES < 2) begin : g_bad_delay
        $error("delayfixed_fall_dig: DELAY_CYCLES must be >= 2");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("delayfixed_fall_dig: SYNC_STAGES must be >= 2");
    end

    // Supply/ground/substrate pins exist only so the cell drops into the
    // analog symbol flow; they carry no logic function.
    logic unused_supply;
    assign unused_supply = CELV ^ CELG ^ CELSUB;

    typedef enum logic [1:0] {
        ST_LOW   = 2'd0,
        ST_HIGH  = 2'd1,
        ST_COUNT = 2'd2
    } state_t;

    // Value of cnt on the edge that completes the DELAY_CYCLES-th low sample.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DELAY_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   i_s;
    state_t                 state;
    logic [CNT_W-1:0]       cnt;

    // Synchroniser chain on the asynchronous input; nothing else looks at i.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i};
        end
    end

    assign i_s = sync_q[SYNC_STAGES-1];

    // Hold-off FSM with registered outputs; an aborted count just returns to
    // HIGH so o never glitches, and an unreachable encoding falls back to LOW.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_LOW;
            cnt        <= '0;
            o          <= 1'b0;
            busy       <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            fall_pulse <= 1'b0;
            case (state)
                ST_LOW: begin
                    o    <= 1'b0;
                    busy <= 1'b0;
                    cnt  <= '0;
                    if (i_s) begin
                        state <= ST_HIGH;
                        o     <= 1'b1;
                    end
                end
                ST_HIGH: begin
                    o    <= 1'b1;
                    busy <= 1'b0;
                    cnt  <= '0;
                    if (!i_s) begin
                        // This edge is the first low sample, so count starts at 1.
                        state <= ST_COUNT;
                        cnt   <= CNT_ONE;
                        busy  <= 1'b1;
                    end
                end
                ST_COUNT: begin
                    if (i_s) begin
                        state <= ST_HIGH;
                        cnt   <= '0;
                        busy  <= 1'b0;
                        o     <= 1'b1;
                    end else if (cnt == CNT_LAST) begin
                        state      <= ST_LOW;
                        cnt        <= '0;
                        o          <= 1'b0;
                        busy       <= 1'b0;
                        fall_pulse <= 1'b1;
                    end else begin
                        cnt  <= cnt + CNT_ONE;
                        o    <= 1'b1;
                        busy <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_LOW;
                    cnt   <= '0;
                    o     <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_delayfixed_fall_dig.sv
// Bench for delayfixed_fall_dig: directed test-plan sequences followed by random
// low/high runs and reset pulses, checked every cycle against a run-length model.
// Outputs sampled 1 time unit after each rising edge; inputs change right after.
module tb_delayfixed_fall_dig;

    localparam int DELAY = 10;
    localparam int SYNC  = 2;

    logic clk;
    logic rst;
    logic CELV, CELG, CELSUB;
    logic i;
    logic o, busy, fall_pulse;

    int vectors;
    int miscompares;

    // Model state: history of sampled i values, consecutive-low run length.
    logic hist [SYNC];
    int   lowrun;
    logic m_o, m_busy, m_fp;

    delayfixed_fall_dig #(
        .DELAY_CYCLES(DELAY),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .CELV      (CELV),
        .CELG      (CELG),
        .CELSUB    (CELSUB),
        .i         (i),
        .o         (o),
        .busy      (busy),
        .fall_pulse(fall_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %b expected %b", tag, $time, obs, exp);
        end
    endtask

    // One clock: advance the model with the inputs seen at this edge, then compare.
    task automatic step();
        logic is_v;
        logic prev_o;
        @(posedge clk);
        if (rst) begin
            for (int k = 0; k < SYNC; k++) hist[k] = 1'b0;
            lowrun = 0;
            m_o    = 1'b0;
            m_busy = 1'b0;
            m_fp   = 1'b0;
        end else begin
            // The level the FSM sees is i as sampled SYNC edges ago.
            is_v = hist[SYNC-1];
            for (int k = SYNC - 1; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = i;
            lowrun = is_v ? 0 : ((lowrun < 1000) ? lowrun + 1 : lowrun);
            prev_o = m_o;
            if (prev_o) m_o = !(lowrun >= DELAY);
            else        m_o = is_v;
            m_fp   = prev_o && !m_o;
            m_busy = m_o && (lowrun > 0);
        end
        #1;
        chk("o", o, m_o);
        chk("busy", busy, m_busy);
        chk("fall_pulse", fall_pulse, m_fp);
    endtask

    task automatic drive(input logic v, input int n);
        i = v;
        repeat (n) step();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        for (int k = 0; k < SYNC; k++) hist[k] = 1'b0;
        lowrun = 0;
        m_o    = 1'b0;
        m_busy = 1'b0;
        m_fp   = 1'b0;
        CELV   = 1'b1;
        CELG   = 1'b0;
        CELSUB = 1'b0;
        rst    = 1'b1;
        i      = 1'b1;

        // Reset held with i high: everything low.
        repeat (3) step();
        rst = 1'b0;

        // Nominal rise then delayed fall.
        drive(1'b1, 20);
        drive(1'b0, 15);

        // Glitch reject (5 low), boundary 9 low (no fall), 10 low (fall).
        drive(1'b1, 10);
        drive(1'b0, 5);
        drive(1'b1, 10);
        drive(1'b0, 9);
        drive(1'b1, 10);
        drive(1'b0, 10);
        drive(1'b1, 10);

        // Reset mid-count, then rise again after release.
        drive(1'b0, 7);
        rst = 1'b1;
        step();
        rst = 1'b0;
        drive(1'b1, 10);

        // Back-to-back: return high on the fall cycle, then a second fall.
        drive(1'b0, 10);
        drive(1'b1, 3);
        drive(1'b0, 10);
        drive(1'b1, 5);
        drive(1'b0, 14);

        // Random runs biased around the hold-off boundary, occasional reset.
        repeat (300) begin
            if ($urandom_range(0, 39) == 0) begin
                rst = 1'b1;
                i   = 1'($urandom_range(0, 1));
                repeat ($urandom_range(1, 3)) step();
                rst = 1'b0;
            end else begin
                drive(1'b0, $urandom_range(1, DELAY + 4));
                drive(1'b1, $urandom_range(1, 6));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
